// File: rtl/mc_pkg.sv
// mc_pkg: shared constants and types for the multicycle MIPS control unit.
//   - State encodings for the control FSM (4-bit base encoding).
//   - Opcode constants decoded in DECODE.
//   - aluop codes consumed by aludec.
//   - alusrcb / pcsrc mux select constants.
//   - ctrl_t: the Moore output bundle produced from the current state.
package mc_pkg;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;
  localparam logic [3:0] S_BNEEX   = 4'd12;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/mc_controller_aludec.sv
// aludec: ALU function decoder shared with the single-cycle control path.
//   funct      [5:0] in  : instr[5:0]
//   aluop      [1:0] in  : 00 add, 01 sub, otherwise funct decode
//   alucontrol [2:0] out : ALU function select
module aludec (
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      default: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b000;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control unit (Moore FSM, 3-5 cycles/instr).
// Optional build macro: MC_CTRL_BNE_EN adds the bne instruction (BNEEX state).
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   op, funct               instruction fields from IR
//   zero                    ALU zero flag (same cycle)
//   pcen                    PC write enable = pcwrite | taken branch
//   memwrite, irwrite,      memory write, IR load,
//   regwrite                register file write
//   alusrca, alusrcb        ALU operand selects
//   iord, memtoreg, regdst  address / writeback data / dest reg selects
//   pcsrc, alucontrol       next-PC select, ALU function
//   state_o                 current state (debug)
module mc_controller
  import mc_pkg::*;
#(
  parameter int STATE_W = 4  // must be >= 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pcen,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [STATE_W-1:0] ST_FETCH   = STATE_W'(S_FETCH);
  localparam logic [STATE_W-1:0] ST_DECODE  = STATE_W'(S_DECODE);
  localparam logic [STATE_W-1:0] ST_MEMADR  = STATE_W'(S_MEMADR);
  localparam logic [STATE_W-1:0] ST_MEMRD   = STATE_W'(S_MEMRD);
  localparam logic [STATE_W-1:0] ST_MEMWB   = STATE_W'(S_MEMWB);
  localparam logic [STATE_W-1:0] ST_MEMWR   = STATE_W'(S_MEMWR);
  localparam logic [STATE_W-1:0] ST_RTYPEEX = STATE_W'(S_RTYPEEX);
  localparam logic [STATE_W-1:0] ST_RTYPEWB = STATE_W'(S_RTYPEWB);
  localparam logic [STATE_W-1:0] ST_BEQEX   = STATE_W'(S_BEQEX);
  localparam logic [STATE_W-1:0] ST_ADDIEX  = STATE_W'(S_ADDIEX);
  localparam logic [STATE_W-1:0] ST_ADDIWB  = STATE_W'(S_ADDIWB);
  localparam logic [STATE_W-1:0] ST_JEX     = STATE_W'(S_JEX);
`ifdef MC_CTRL_BNE_EN
  localparam logic [STATE_W-1:0] ST_BNEEX   = STATE_W'(S_BNEEX);
`endif

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  ctrl_t              w_ctrl;
`ifdef MC_CTRL_BNE_EN
  logic               w_bne;
`endif

  // Reset forces FETCH immediately; since every output is decoded from the
  // state, no write strobe from an interrupted instruction survives reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = ST_FETCH;
    case (r_state)
      ST_FETCH: w_next = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = ST_MEMADR;
          OP_RTYPE:     w_next = ST_RTYPEEX;
          OP_BEQ:       w_next = ST_BEQEX;
          OP_ADDI:      w_next = ST_ADDIEX;
          OP_J:         w_next = ST_JEX;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       w_next = ST_BNEEX;
`endif
          // Unsupported op acts as a NOP: PC already advanced in FETCH.
          default:      w_next = ST_FETCH;
        endcase
      end
      ST_MEMADR:  w_next = (op == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:   w_next = ST_MEMWB;
      ST_RTYPEEX: w_next = ST_RTYPEWB;
      ST_ADDIEX:  w_next = ST_ADDIWB;
      default:    w_next = ST_FETCH;
    endcase
  end

  // Unused state encodings fall into the default arm and decode as FETCH.
  always_comb begin
    w_ctrl = '0;
`ifdef MC_CTRL_BNE_EN
    w_bne  = 1'b0;
`endif
    case (r_state)
      ST_DECODE: w_ctrl.alusrcb = SRCB_IMMSH;
      ST_MEMADR: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.alusrcb = SRCB_IMM;
      end
      ST_MEMRD: w_ctrl.iord = 1'b1;
      ST_MEMWB: begin
        w_ctrl.memtoreg = 1'b1;
        w_ctrl.regwrite = 1'b1;
      end
      ST_MEMWR: begin
        w_ctrl.iord     = 1'b1;
        w_ctrl.memwrite = 1'b1;
      end
      ST_RTYPEEX: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.alusrcb = SRCB_B;
        w_ctrl.aluop   = ALUOP_FUNCT;
      end
      ST_RTYPEWB: begin
        w_ctrl.regdst   = 1'b1;
        w_ctrl.regwrite = 1'b1;
      end
      ST_BEQEX: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.aluop   = ALUOP_SUB;
        w_ctrl.pcsrc   = PCSRC_ALUOUT;
        w_ctrl.branch  = 1'b1;
      end
`ifdef MC_CTRL_BNE_EN
      ST_BNEEX: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.aluop   = ALUOP_SUB;
        w_ctrl.pcsrc   = PCSRC_ALUOUT;
        w_bne          = 1'b1;
      end
`endif
      ST_ADDIEX: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.alusrcb = SRCB_IMM;
      end
      ST_ADDIWB: w_ctrl.regwrite = 1'b1;
      ST_JEX: begin
        w_ctrl.pcsrc   = PCSRC_JUMP;
        w_ctrl.pcwrite = 1'b1;
      end
      default: begin
        w_ctrl.irwrite = 1'b1;
        w_ctrl.pcwrite = 1'b1;
        w_ctrl.alusrcb = SRCB_FOUR;
        w_ctrl.pcsrc   = PCSRC_ALU;
      end
    endcase
  end

  aludec u_aludec (
    .funct      (funct),
    .aluop      (w_ctrl.aluop),
    .alucontrol (alucontrol)
  );

  // pcen is the only Mealy-style output: it folds in the live zero flag.
`ifdef MC_CTRL_BNE_EN
  assign pcen = w_ctrl.pcwrite | (w_ctrl.branch & zero) | (w_bne & ~zero);
`else
  assign pcen = w_ctrl.pcwrite | (w_ctrl.branch & zero);
`endif

  assign memwrite = w_ctrl.memwrite;
  assign irwrite  = w_ctrl.irwrite;
  assign regwrite = w_ctrl.regwrite;
  assign alusrca  = w_ctrl.alusrca;
  assign alusrcb  = w_ctrl.alusrcb;
  assign iord     = w_ctrl.iord;
  assign memtoreg = w_ctrl.memtoreg;
  assign regdst   = w_ctrl.regdst;
  assign pcsrc    = w_ctrl.pcsrc;
  assign state_o  = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: per-instruction scenarios with a queue of
// expected per-cycle output vectors built from the instruction tables.
module tb_mc_controller;
  import mc_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_o;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mc_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .iord(iord), .memtoreg(memtoreg),
    .regdst(regdst), .pcsrc(pcsrc), .alucontrol(alucontrol), .state_o(state_o)
  );

  function automatic logic [2:0] fdec(logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  // Expected outputs for a state, written from the instruction tables.
  function automatic exp_t model(logic [3:0] st, logic [5:0] fn, logic z);
    exp_t e;
    e = '0;
    e.st = st;
    e.alucontrol = 3'b010;
    case (st)
      S_DECODE:  e.alusrcb = 2'b11;
      S_MEMADR:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      S_MEMRD:   e.iord = 1;
      S_MEMWB:   begin e.memtoreg = 1; e.regwrite = 1; end
      S_MEMWR:   begin e.iord = 1; e.memwrite = 1; end
      S_RTYPEEX: begin e.alusrca = 1; e.alucontrol = fdec(fn); end
      S_RTYPEWB: begin e.regdst = 1; e.regwrite = 1; end
      S_BEQEX:   begin e.alusrca = 1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
      S_BNEEX:   begin e.alusrca = 1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcen = ~z; end
      S_ADDIEX:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      S_ADDIWB:  e.regwrite = 1;
      S_JEX:     begin e.pcsrc = 2'b10; e.pcen = 1; end
      default:   begin e.irwrite = 1; e.pcen = 1; e.alusrcb = 2'b01; end
    endcase
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t g;
    g.st = state_o; g.pcen = pcen; g.memwrite = memwrite; g.irwrite = irwrite;
    g.regwrite = regwrite; g.alusrca = alusrca; g.alusrcb = alusrcb; g.iord = iord;
    g.memtoreg = memtoreg; g.regdst = regdst; g.pcsrc = pcsrc; g.alucontrol = alucontrol;
    return g;
  endfunction

  task automatic push(logic [3:0] st);
    sb.push_back(model(st, funct, zero));
  endtask

  task automatic test_reset();
    exp_t g;
    reset_n = 1'b0; op = 6'b111111; funct = 6'd0; zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    g = sample();
    n_cmp++;
    if (g !== model(S_FETCH, 6'd0, 1'b0)) begin
      n_bad++; $display("FAIL reset_state got=%h exp=%h", g, model(S_FETCH, 6'd0, 1'b0));
    end
    n_cmp++;
    if ({irwrite, pcen, alusrcb, regwrite, memwrite} !== 6'b110100) begin
      n_bad++; $display("FAIL reset_outputs got=%b exp=110100", {irwrite, pcen, alusrcb, regwrite, memwrite});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_lw();
    exp_t e, g;
    int nrw = 0;
    op = OP_LW; funct = 6'b000000; zero = 1'b0;
    push(S_FETCH); push(S_DECODE); push(S_MEMADR); push(S_MEMRD); push(S_MEMWB);
    while (sb.size() > 0) begin
      #1; e = sb.pop_front(); g = sample();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL lw_cycle got=%h exp=%h", g, e); end
      if (regwrite === 1'b1) nrw++;
      @(negedge clk);
    end
    n_cmp++;
    if (nrw != 1) begin n_bad++; $display("FAIL lw_regwrite_cycles got=%0d exp=1", nrw); end
  endtask

  task automatic test_sw();
    exp_t e, g;
    int nmw = 0;
    int nrw = 0;
    op = OP_SW; funct = 6'b100000; zero = 1'b1;
    push(S_FETCH); push(S_DECODE); push(S_MEMADR); push(S_MEMWR);
    while (sb.size() > 0) begin
      #1; e = sb.pop_front(); g = sample();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL sw_cycle got=%h exp=%h", g, e); end
      if (memwrite === 1'b1 && iord === 1'b1) nmw++;
      if (regwrite === 1'b1) nrw++;
      @(negedge clk);
    end
    n_cmp++;
    if (nmw != 1 || nrw != 0) begin
      n_bad++; $display("FAIL sw_strobes got=%0d/%0d exp=1/0", nmw, nrw);
    end
  endtask

  task automatic test_rtype(logic [5:0] fn);
    exp_t e, g;
    op = OP_RTYPE; funct = fn; zero = 1'b0;
    push(S_FETCH); push(S_DECODE); push(S_RTYPEEX); push(S_RTYPEWB);
    while (sb.size() > 0) begin
      #1; e = sb.pop_front(); g = sample();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL rtype_%b got=%h exp=%h", fn, g, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_beq(logic z);
    exp_t e, g;
    op = OP_BEQ; funct = 6'b100101; zero = z;
    push(S_FETCH); push(S_DECODE); push(S_BEQEX);
    while (sb.size() > 0) begin
      #1; e = sb.pop_front(); g = sample();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL beq_z%0d got=%h exp=%h", z, g, e); end
      if (e.st == S_BEQEX) begin
        n_cmp++;
        if (pcen !== z) begin n_bad++; $display("FAIL beq_pcen got=%b exp=%b", pcen, z); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_jump_and_nop();
    exp_t e, g;
    op = OP_J; funct = 6'd0; zero = 1'b0;
    push(S_FETCH); push(S_DECODE); push(S_JEX);
    while (sb.size() > 0) begin
      #1; e = sb.pop_front(); g = sample();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL j_cycle got=%h exp=%h", g, e); end
      @(negedge clk);
    end
    op = 6'b111111;
    push(S_FETCH); push(S_DECODE);
    while (sb.size() > 0) begin
      #1; e = sb.pop_front(); g = sample();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL nop_cycle got=%h exp=%h", g, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_bne();
    exp_t e, g;
    op = OP_BNE; funct = 6'd0; zero = 1'b0;
    push(S_FETCH); push(S_DECODE);
`ifdef MC_CTRL_BNE_EN
    push(S_BNEEX);
`endif
    while (sb.size() > 0) begin
      #1; e = sb.pop_front(); g = sample();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL bne_cycle got=%h exp=%h", g, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, g;
    logic [5:0] fns [4] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};
    for (int k = 0; k < 4; k++) begin
      op = OP_ADDI; funct = fns[$urandom_range(3, 0)]; zero = k[0];
      push(S_FETCH); push(S_DECODE); push(S_ADDIEX); push(S_ADDIWB);
      while (sb.size() > 0) begin
        #1; e = sb.pop_front(); g = sample();
        n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL addi_cycle got=%h exp=%h", g, e); end
        @(negedge clk);
      end
      test_rtype(fns[k]);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, g;
    op = OP_LW; funct = 6'd0; zero = 1'b0;
    push(S_FETCH); push(S_DECODE); push(S_MEMADR); push(S_MEMRD); push(S_MEMWB);
    for (int i = 0; i < 5; i++) begin
      #1; e = sb.pop_front(); g = sample();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL mid_cycle got=%h exp=%h", g, e); end
      if (i < 4) @(negedge clk);
    end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (state_o !== S_FETCH || regwrite !== 1'b0 || memtoreg !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset got=%h/%b exp=%h/0", state_o, regwrite, S_FETCH);
    end
    @(negedge clk);
    reset_n = 1'b1;
    op = OP_BEQ; zero = 1'b1;
    push(S_FETCH); push(S_DECODE); push(S_BEQEX); push(S_FETCH);
    while (sb.size() > 0) begin
      #1; e = sb.pop_front(); g = sample();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL post_reset got=%h exp=%h", g, e); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype(6'b101010);
    test_beq(1'b1);
    test_beq(1'b0);
    test_jump_and_nop();
    test_bne();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle MIPS control unit: a Moore FSM that sequences a shared-memory, single-ALU datapath over 3–5 cycles per instruction.
- Successor to the single-cycle control path. Drives PC, IR, register-file, memory and ALU mux enables from `op` and `funct` each cycle.
- Reuses the existing `aludec` for ALU function decode.

Parameters:
- STATE_W, 4, width of state register. Must be ≥4 (12 states).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- op  input  6  instr[31:26] from IR (valid from DECODE onward)
- funct  input  6  instr[5:0] from IR
- zero  input  1  ALU zero flag, same cycle
- pcen  output  1  PC register write enable
- memwrite  output  1  memory write strobe
- irwrite  output  1  instruction register load
- regwrite  output  1  register file write
- alusrca  output  1  0=PC, 1=register A
- alusrcb  output  2  00=B, 01=const 4, 10=signimm, 11=signimm<<2
- iord  output  1  0=PC address, 1=ALUOut address
- memtoreg  output  1  0=ALUOut, 1=Data register
- regdst  output  1  0=rt, 1=rd
- pcsrc  output  2  00=ALU result, 01=ALUOut, 10=jump target
- alucontrol  output  3  ALU function
- state_o  output  STATE_W  current state (debug/verification)

Behaviour:
- Reset: async assert of reset_n=0 forces state=FETCH immediately. Exit is synchronous at the first clk edge after deassert.
  - While in reset, outputs equal the FETCH decode: irwrite=1, pcen=1, alusrcb=01, all other enables 0, mux selects 00/0.
  - Deassert mid-instruction always restarts at FETCH. No partial write completes after reset is asserted.
- All outputs except pcen are a pure function of state (Moore).
  - pcen = pcwrite | (branch & zero), combinational.
  - Internal aluop drives aludec:
    - aluop 00 → alucontrol 010 (add)
    - aluop 01 → 110 (sub)
    - aluop 10 → funct decode: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, other→xxx (drive 000)
- States, with asserted signals and transitions (one state per clock):
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite, pcwrite → DECODE
  - DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
    - lw 100011 / sw 101011 → MEMADR
    - R-type 000000 → RTYPEEX
    - beq 000100 → BEQEX
    - addi 001000 → ADDIEX
    - j 000010 → JEX
    - any other op → FETCH (treated as NOP; pcen already advanced)
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. lw→MEMRD, sw→MEMWR.
  - MEMRD: iord=1 → MEMWB
  - MEMWB: regdst=0, memtoreg=1, regwrite → FETCH
  - MEMWR: iord=1, memwrite → FETCH
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10 → RTYPEWB
  - RTYPEWB: regdst=1, memtoreg=0, regwrite → FETCH
  - BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch → FETCH
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00 → ADDIWB
  - ADDIWB: regdst=0, memtoreg=0, regwrite → FETCH
  - JEX: pcsrc=10, pcwrite → FETCH
- Latency in cycles: lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; unsupported op 2.
- regwrite and memwrite are never asserted in the same cycle. irwrite is asserted only in FETCH.
- Unused encodings of the state register → next state FETCH, outputs as FETCH.

Optional Feature:
- Macro MC_CTRL_BNE_EN.
- Defined: op 000101 (bne) in DECODE → BNEEX.
  - BNEEX has the same outputs as BEQEX, except pcen = pcwrite | (bne & ~zero).
  - Exits to FETCH.
- Undefined: op 000101 is an unsupported op (DECODE→FETCH); BNEEX state is absent.

Decomposition:
- Shared package (mc_pkg): state encodings, opcode constants (OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J, OP_BNE), aluop codes, alusrcb/pcsrc select constants.
- Sub-module: existing `aludec`, instantiated unchanged (funct, aluop → alucontrol).
- FSM next-state and output decode stay in mc_controller.

Test Plan:
- Reset then lw:
  - Stimulus: reset_n=0 for 2 cycles, release, op=100011.
  - Required: state_o sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH.
  - Required: regwrite=1 and memtoreg=1 only in MEMWB; alucontrol=010 in MEMADR.
- sw:
  - Stimulus: op=101011.
  - Required: memwrite=1 and iord=1 for exactly 1 cycle (MEMWR); regwrite never 1; back in FETCH after 4 cycles.
- R-type slt:
  - Stimulus: op=000000, funct=101010.
  - Required: RTYPEEX alucontrol=111, alusrcb=00; RTYPEWB regdst=1, regwrite=1.
- beq taken vs not taken:
  - Stimulus: op=000100 with zero=1 in BEQEX.
  - Required: pcen=1, pcsrc=01, alucontrol=110.
  - Repeat with zero=0: pcen=0 in BEQEX.
- j, then unsupported op:
  - Stimulus: op=000010.
  - Required: JEX pcsrc=10, pcen=1.
  - Stimulus: op=111111.
  - Required: DECODE→FETCH with no regwrite or memwrite.
- Reset mid-instruction:
  - Stimulus: assert reset_n=0 asynchronously while in MEMWB.
  - Required: state_o=FETCH and regwrite=0 within the same cycle, no clock edge needed.
- With MC_CTRL_BNE_EN:
  - Stimulus: op=000101, zero=0.
  - Required: pcen=1 in BNEEX.
